// File: rtl/matvec_engine.sv
// Matrix-vector multiply engine: fetches B and a ROWS x COLS A matrix over an
// Avalon-MM read master, then accumulates C[r] += A[r][k]*B[k] on ROWS lanes.
module matvec_engine #(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 24,
    parameter int ADDR_WIDTH  = 32,
    parameter int ADDR_STRIDE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       accum,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    output logic [ADDR_WIDTH-1:0]      address,
    output logic                       read,
    input  logic [COLS*DATA_WIDTH-1:0] readdata,
    input  logic                       readdatavalid,
    input  logic                       waitrequest,
    output logic                       busy,
    output logic                       done,
    output logic [ROWS*ACC_WIDTH-1:0]  c_out
);

    localparam int WORDS = ROWS + 1;
    localparam int CW    = $clog2(WORDS + 1);
    localparam int KW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int XW    = (2 * DATA_WIDTH > ACC_WIDTH) ? 2 * DATA_WIDTH : ACC_WIDTH;

    typedef enum logic [1:0] {IDLE, FETCH, CALC, DONE} state_t;

    state_t                      state_r, state_s;
    logic [CW-1:0]               issue_cnt_r, rx_cnt_r;
    logic [KW-1:0]               k_r;
    logic [ADDR_WIDTH-1:0]       address_r;
    logic                        read_r, busy_r, done_r;
    logic [COLS*DATA_WIDTH-1:0]  b_vec_r;
    logic [COLS*DATA_WIDTH-1:0]  a_mat_r [ROWS];
    logic [ACC_WIDTH-1:0]        acc_r [ROWS];
    logic [ROWS*ACC_WIDTH-1:0]   c_out_r;
    logic                        start_s, clear_s, accept_s, rx_s, rx_last_s, last_step_s;

    // Product is zero-extended or truncated to the accumulator, sum wraps.
    function automatic logic [ACC_WIDTH-1:0] mac_step(
        input logic [ACC_WIDTH-1:0]  acc,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [2*DATA_WIDTH-1:0] prod;
        logic [XW-1:0]           prod_x;
        prod   = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
        prod_x = XW'(prod);
        return acc + prod_x[ACC_WIDTH-1:0];
    endfunction

    assign address = address_r;
    assign read    = read_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign c_out   = c_out_r;

    // Event decode shared by the datapath and the state machine.
    always_comb begin
        start_s     = (state_r == IDLE) && start;
        clear_s     = start_s && !accum;
        accept_s    = (state_r == FETCH) && read_r && !waitrequest;
        rx_s        = (state_r == FETCH) && readdatavalid && (rx_cnt_r < CW'(WORDS));
        rx_last_s   = rx_s && (rx_cnt_r == CW'(WORDS - 1));
        last_step_s = (state_r == CALC) && (k_r == KW'(COLS - 1));
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = FETCH;
                else       state_s = IDLE;
            end
            FETCH: begin
                if (rx_last_s) state_s = CALC;
                else           state_s = FETCH;
            end
            CALC: begin
                if (last_step_s) state_s = DONE;
                else             state_s = CALC;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register and handshake outputs; done trails DONE so c_out is final with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == FETCH) || (state_s == CALC) || (state_s == DONE);
            done_r  <= (state_r == DONE);
        end
    end

    // Issue side: address and read are held while waitrequest stalls the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            address_r   <= {ADDR_WIDTH{1'b0}};
            read_r      <= 1'b0;
            issue_cnt_r <= {CW{1'b0}};
        end else if (start_s) begin
            address_r   <= base_addr;
            read_r      <= 1'b1;
            issue_cnt_r <= {CW{1'b0}};
        end else if (accept_s) begin
            issue_cnt_r <= issue_cnt_r + CW'(1);
            if (issue_cnt_r == CW'(WORDS - 1)) begin
                read_r <= 1'b0;
            end else begin
                address_r <= address_r + ADDR_WIDTH'(ADDR_STRIDE);
            end
        end
    end

    // Receive side: in-order responses fill slot 0 (B) then rows 0..ROWS-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt_r <= {CW{1'b0}};
            b_vec_r  <= {(COLS*DATA_WIDTH){1'b0}};
            for (int r = 0; r < ROWS; r++) a_mat_r[r] <= {(COLS*DATA_WIDTH){1'b0}};
        end else if (start_s) begin
            rx_cnt_r <= {CW{1'b0}};
        end else if (rx_s) begin
            rx_cnt_r <= rx_cnt_r + CW'(1);
            if (rx_cnt_r == {CW{1'b0}}) b_vec_r <= readdata;
            for (int r = 0; r < ROWS; r++) begin
                if (rx_cnt_r == CW'(r + 1)) a_mat_r[r] <= readdata;
            end
        end
    end

    // MAC lanes: one column per cycle during CALC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_r <= {KW{1'b0}};
            for (int r = 0; r < ROWS; r++) acc_r[r] <= {ACC_WIDTH{1'b0}};
        end else if (clear_s) begin
            k_r <= {KW{1'b0}};
            for (int r = 0; r < ROWS; r++) acc_r[r] <= {ACC_WIDTH{1'b0}};
        end else if (rx_last_s) begin
            k_r <= {KW{1'b0}};
        end else if (state_r == CALC) begin
            k_r <= k_r + KW'(1);
            for (int r = 0; r < ROWS; r++) begin
                acc_r[r] <= mac_step(acc_r[r],
                                     a_mat_r[r][k_r*DATA_WIDTH +: DATA_WIDTH],
                                     b_vec_r[k_r*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

    // Result register mirrors the accumulators one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_out_r <= {(ROWS*ACC_WIDTH){1'b0}};
        end else if (clear_s) begin
            c_out_r <= {(ROWS*ACC_WIDTH){1'b0}};
        end else begin
            for (int r = 0; r < ROWS; r++) c_out_r[r*ACC_WIDTH +: ACC_WIDTH] <= acc_r[r];
        end
    end

endmodule

// File: tb/tb_matvec_engine.sv
// Directed bench for matvec_engine: 8x8 engine on an Avalon memory model with
// 2-cycle read latency and optional waitrequest stalls; a 16-bit-acc twin shares the bus.
module tb_matvec_engine;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int DW   = 8;
    localparam int AW   = 32;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 accum = 1'b0;
    logic [AW-1:0]        base_addr = 32'h0;
    logic [AW-1:0]        address, address2;
    logic                 read, read2, busy, busy2, done, done2;
    logic [COLS*DW-1:0]   readdata;
    logic                 readdatavalid;
    logic                 waitrequest;
    logic [ROWS*24-1:0]   c_out;
    logic [ROWS*16-1:0]   c_out2;

    logic [63:0]          mem [0:8];
    int                   stall_cfg = 0;
    int                   stall_rem = 0;
    logic                 wr = 1'b0;
    logic                 p1_v = 1'b0, rdv_m = 1'b0;
    logic [63:0]          p1_d = 64'h0, rd_m = 64'h0;
    logic                 spur = 1'b0;
    logic [63:0]          spur_data = 64'h0;
    logic                 stall_seen = 1'b0;
    logic [AW-1:0]        stall_addr = 32'h0;
    int                   cyc = 0, acc_cnt = 0, rdv_cnt = 0, rdv_edge = 0, stab_err = 0, done_cnt = 0;
    int                   hits [0:8] = '{default: 0};
    int                   errors = 0, checks = 0;

    assign readdatavalid = rdv_m | spur;
    assign readdata      = spur ? spur_data : rd_m;
    assign waitrequest   = wr;

    matvec_engine #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(24),
                    .ADDR_WIDTH(AW), .ADDR_STRIDE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .accum(accum), .base_addr(base_addr),
        .address(address), .read(read), .readdata(readdata), .readdatavalid(readdatavalid),
        .waitrequest(waitrequest), .busy(busy), .done(done), .c_out(c_out));

    matvec_engine #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(16),
                    .ADDR_WIDTH(AW), .ADDR_STRIDE(1)) dut16 (
        .clk(clk), .rst(rst), .start(start), .accum(accum), .base_addr(base_addr),
        .address(address2), .read(read2), .readdata(readdata), .readdatavalid(readdatavalid),
        .waitrequest(waitrequest), .busy(busy2), .done(done2), .c_out(c_out2));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    // Memory model: words 0x100..0x108, stalls of stall_cfg cycles per read, 2-cycle latency.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_v       <= 1'b0;
            rdv_m      <= 1'b0;
            wr         <= (stall_cfg > 0);
            stall_rem  <= stall_cfg;
            stall_seen <= 1'b0;
        end else begin
            p1_v  <= 1'b0;
            rdv_m <= p1_v;
            rd_m  <= p1_d;
            if (rdv_m) begin
                rdv_cnt  <= rdv_cnt + 1;
                rdv_edge <= cyc;
            end
            if (stall_seen && (!read || address != stall_addr)) stab_err <= stab_err + 1;
            stall_seen <= read && wr;
            stall_addr <= address;
            if (read && !wr) begin
                acc_cnt <= acc_cnt + 1;
                p1_v    <= 1'b1;
                if (address >= 32'h100 && address <= 32'h108) begin
                    hits[address - 32'h100] <= hits[address - 32'h100] + 1;
                    p1_d <= mem[address - 32'h100];
                end else begin
                    p1_d <= 64'h0;
                end
                stall_rem <= stall_cfg;
                wr        <= (stall_cfg > 0);
            end else if (read) begin
                if (stall_rem <= 1) wr <= 1'b0;
                stall_rem <= stall_rem - 1;
            end else begin
                wr        <= (stall_cfg > 0);
                stall_rem <= stall_cfg;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lanes(input string tag, input int mult);
        for (int r = 0; r < ROWS; r++)
            chk($sformatf("%s[%0d]", tag, r), 64'(c_out[r*24 +: 24]), 64'((r + 1) * mult));
    endtask

    task automatic load_identity();
        logic [63:0] w;
        w = 64'h0;
        for (int k = 0; k < COLS; k++) w[k*8 +: 8] = 8'(k + 1);
        mem[0] = w;
        for (int r = 0; r < ROWS; r++) begin
            w = 64'h0;
            w[r*8 +: 8] = 8'h01;
            mem[r + 1] = w;
        end
    endtask

    // Starts a run and waits (bounded) for done; optionally pulses start again during CALC.
    task automatic run(input logic acc_mode, input logic extra_start);
        int got;
        int r0;
        got = 0;
        r0  = rdv_cnt;
        @(negedge clk);
        base_addr = 32'h100;
        accum     = acc_mode;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        accum = 1'b0;
        chk("busy_after_start", 64'(busy), 64'h1);
        if (extra_start) begin
            for (int i = 0; i < 200 && rdv_cnt < r0 + ROWS + 1; i++) @(negedge clk);
            @(negedge clk);
            @(negedge clk);
            base_addr = 32'h200;
            start     = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk("done_seen", 64'(got), 64'h1);
        // done rises on the COLS+1-th edge after the edge that sampled the last response
        chk("done_latency", 64'((cyc - 1) - rdv_edge), 64'(COLS + 1));
        chk("busy_at_done", 64'(busy), 64'h0);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'h0);
    endtask

    initial begin
        int d0, a0;
        load_identity();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_read", 64'(read), 64'h0);
        chk("rst_address", 64'(address), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_c_out", 64'(c_out != '0), 64'h0);

        // Identity A, B = 1..8
        d0 = done_cnt;
        run(1'b0, 1'b0);
        chk_lanes("ident", 1);
        chk("ident_reads", 64'(acc_cnt), 64'd9);
        for (int i = 0; i < 9; i++) chk($sformatf("ident_hit[%0d]", i), 64'(hits[i]), 64'h1);
        chk("ident_done_cnt", 64'(done_cnt - d0), 64'h1);

        // Accumulate across runs, then a clearing run
        run(1'b1, 1'b0);
        chk_lanes("accum", 2);
        run(1'b0, 1'b0);
        chk_lanes("reclear", 1);

        // All 0xFF: 24-bit lanes hold 520200, 16-bit lanes wrap to 0xF008
        for (int i = 0; i < 9; i++) mem[i] = 64'hFFFF_FFFF_FFFF_FFFF;
        run(1'b0, 1'b0);
        for (int r = 0; r < ROWS; r++) begin
            chk($sformatf("ff24[%0d]", r), 64'(c_out[r*24 +: 24]), 64'h07F008);
            chk($sformatf("ff16[%0d]", r), 64'(c_out2[r*16 +: 16]), 64'hF008);
        end

        // Three-cycle waitrequest stall on every read
        load_identity();
        stall_cfg = 3;
        a0 = acc_cnt;
        run(1'b0, 1'b0);
        chk_lanes("stall", 1);
        chk("stall_reads", 64'(acc_cnt - a0), 64'd9);
        chk("stall_stable", 64'(stab_err), 64'h0);
        stall_cfg = 0;
        @(negedge clk);

        // start pulsed during CALC is ignored
        d0 = done_cnt;
        run(1'b0, 1'b1);
        chk_lanes("calc_start", 1);
        repeat (20) @(negedge clk);
        chk("calc_start_done_cnt", 64'(done_cnt - d0), 64'h1);
        chk("calc_start_idle", 64'(busy), 64'h0);

        // Spurious readdatavalid in IDLE changes nothing
        spur_data = 64'hDEAD_BEEF_CAFE_F00D;
        spur = 1'b1;
        repeat (2) @(negedge clk);
        spur = 1'b0;
        repeat (12) @(negedge clk);
        chk("spur_busy", 64'(busy), 64'h0);
        chk("spur_read", 64'(read), 64'h0);
        chk_lanes("spur", 1);

        // Reset during FETCH after four accepted reads
        a0 = acc_cnt;
        d0 = done_cnt;
        @(negedge clk);
        base_addr = 32'h100;
        accum     = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && acc_cnt < a0 + 4; i++) @(negedge clk);
        chk("mid_reads_reached", 64'(acc_cnt - a0 >= 4), 64'h1);
        chk("mid_c_out_kept", 64'(c_out[23:0]), 64'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_read", 64'(read), 64'h0);
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_c_out", 64'(c_out != '0), 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_rst_no_done", 64'(done_cnt - d0), 64'h0);
        chk("mid_rst_idle", 64'(busy), 64'h0);
        run(1'b0, 1'b0);
        chk_lanes("after_rst", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
